// File: rtl/sigan_mc_if.sv
// Probe bus for sigan_mc: gate qualifiers and probe data in, window signatures and status out.
interface sigan_mc_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 1
);
    logic                      start;
    logic                      stop;
    logic [CHANNELS-1:0]       data;
    logic                      single;
    logic                      arm;
    logic [CHANNELS*WIDTH-1:0] signature;
    logic                      sig_valid;
    logic                      gate;
    logic [31:0]               count;
    logic [CHANNELS-1:0]       unstable;

    modport master (
        output start, stop, data, single, arm,
        input  signature, sig_valid, gate, count, unstable
    );

    modport slave (
        input  start, stop, data, single, arm,
        output signature, sig_valid, gate, count, unstable
    );
endinterface

// File: rtl/sigan_mc.sv
// Multi-channel signature analyser: per-channel LFSR compaction over a start/stop gated window.
// Optional feature macro: SIGAN_UNSTABLE_EN (per-channel signature-changed flags).
module sigan_mc #(
    parameter int               WIDTH       = 16,
    parameter int               CHANNELS    = 1,
    parameter logic [WIDTH-1:0] POLY        = 16'h8940,
    parameter bit               START_LEVEL = 1'b0,
    parameter bit               STOP_LEVEL  = 1'b0
) (
    input  logic       clock,
    input  logic       reset_l,
    sigan_mc_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t                          r_state;
    logic                            r_boot;
    logic                            r_start_q;
    logic                            r_stop_q;
    logic [CHANNELS-1:0][WIDTH-1:0]  r_lfsr;
    logic [31:0]                     r_counter;
    logic [CHANNELS-1:0][WIDTH-1:0]  r_signature;
    logic [31:0]                     r_count;
    logic                            r_sig_valid;
    logic                            r_gate;

    state_t                          w_cur_state;
    state_t                          w_next_state;
    logic                            w_start_ev;
    logic                            w_stop_ev;
    logic                            w_load;
    logic                            w_shift;
    logic                            w_done;
    logic [CHANNELS-1:0][WIDTH-1:0]  w_lfsr_next;
    logic [31:0]                     w_counter_next;

    // The post-reset state depends on single, so it is resolved at the first edge after reset.
    assign w_cur_state = r_boot ? (bus.single ? ST_IDLE : ST_WAIT) : r_state;
    assign w_start_ev  = START_LEVEL ? bus.start : (bus.start & ~r_start_q);
    assign w_stop_ev   = STOP_LEVEL  ? bus.stop  : (bus.stop  & ~r_stop_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= ST_WAIT;
            r_boot  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_boot  <= 1'b0;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = w_cur_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        unique case (w_cur_state)
            ST_IDLE: begin
                if (bus.arm) w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_start_ev) begin
                    w_load = 1'b1;
                    if (w_stop_ev) w_done = 1'b1;
                    else           w_next_state = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                w_shift = 1'b1;
                if (w_stop_ev) w_done = 1'b1;
            end
            default: w_next_state = ST_WAIT;
        endcase
        if (w_done) w_next_state = bus.single ? ST_IDLE : ST_WAIT;
    end

    // Loading from the zero state reduces one shift to just the data bit in bit 0.
    always_comb begin
        w_lfsr_next = r_lfsr;
        for (int n = 0; n < CHANNELS; n++) begin
            if (w_load)
                w_lfsr_next[n] = {{(WIDTH-1){1'b0}}, bus.data[n]};
            else
                w_lfsr_next[n] = {r_lfsr[n][WIDTH-2:0], bus.data[n] ^ (^(r_lfsr[n] & POLY))};
        end
        if (w_load)          w_counter_next = 32'd1;
        else if (&r_counter) w_counter_next = r_counter;
        else                 w_counter_next = r_counter + 32'd1;
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            r_start_q   <= 1'b1;
            r_stop_q    <= 1'b1;
            r_lfsr      <= '0;
            r_counter   <= '0;
            r_signature <= '0;
            r_count     <= '0;
            r_sig_valid <= 1'b0;
            r_gate      <= 1'b0;
        end else begin
            r_start_q   <= bus.start;
            r_stop_q    <= bus.stop;
            if (w_load || w_shift) begin
                r_lfsr    <= w_lfsr_next;
                r_counter <= w_counter_next;
            end
            if (w_done) begin
                r_signature <= w_lfsr_next;
                r_count     <= w_counter_next;
            end
            r_sig_valid <= w_done;
            r_gate      <= (w_next_state == ST_MEASURE);
        end
    end

    assign bus.signature = r_signature;
    assign bus.count     = r_count;
    assign bus.sig_valid = r_sig_valid;
    assign bus.gate      = r_gate;

`ifdef SIGAN_UNSTABLE_EN
    logic                r_have_sig;
    logic [CHANNELS-1:0] r_unstable;

    // The first window after reset has nothing to compare against, so it never flags.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            r_have_sig <= 1'b0;
            r_unstable <= '0;
        end else if (w_done) begin
            r_have_sig <= 1'b1;
            for (int n = 0; n < CHANNELS; n++)
                r_unstable[n] <= r_have_sig && (w_lfsr_next[n] != r_signature[n]);
        end
    end

    assign bus.unstable = r_unstable;
`else
    assign bus.unstable = '0;
`endif

endmodule

// File: tb/tb_sigan_mc.sv
// Self-checking bench for sigan_mc: directed windows plus random gating against a sample-queue model.
module tb_sigan_mc;

    localparam int               WIDTH    = 16;
    localparam int               CHANNELS = 2;
    localparam logic [WIDTH-1:0] POLY     = 16'h8940;

    logic clock   = 1'b0;
    logic reset_l = 1'b0;

    sigan_mc_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    sigan_mc #(
        .WIDTH       (WIDTH),
        .CHANNELS    (CHANNELS),
        .POLY        (POLY),
        .START_LEVEL (1'b0),
        .STOP_LEVEL  (1'b0)
    ) dut (
        .clock   (clock),
        .reset_l (reset_l),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid_seen = 0;

    // Reference model: a window is simply the list of data samples taken between its start and stop events.
    int                        m_phase;      // 0 idle (needs arm), 1 waiting for start, 2 measuring
    logic                      m_prev_start;
    logic                      m_prev_stop;
    logic [CHANNELS-1:0]       m_samples[$];
    logic [CHANNELS*WIDTH-1:0] m_sig;
    logic [31:0]               m_count;
    logic                      m_valid;
    logic [CHANNELS-1:0]       m_unstable;
    bit                        m_have_sig;

    function automatic logic [WIDTH-1:0] fold(int ch);
        logic [WIDTH-1:0] s;
        s = '0;
        foreach (m_samples[i])
            s = {s[WIDTH-2:0], m_samples[i][ch] ^ (^(s & POLY))};
        return s;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        check({tag, ".gate"},      64'(bus.gate),      64'(m_phase == 2));
        check({tag, ".sig_valid"}, 64'(bus.sig_valid), 64'(m_valid));
        check({tag, ".signature"}, 64'(bus.signature), 64'(m_sig));
        check({tag, ".count"},     64'(bus.count),     64'(m_count));
        check({tag, ".unstable"},  64'(bus.unstable),  64'(m_unstable));
        if (bus.sig_valid === 1'b1) n_valid_seen++;
    endtask

    task automatic model_reset();
        m_phase      = bus.single ? 0 : 1;
        m_prev_start = 1'b1;
        m_prev_stop  = 1'b1;
        m_samples.delete();
        m_sig        = '0;
        m_count      = '0;
        m_valid      = 1'b0;
        m_unstable   = '0;
        m_have_sig   = 1'b0;
    endtask

    task automatic model_edge(logic st, logic sp, logic [CHANNELS-1:0] d, logic ar, logic sg);
        bit ev_start;
        bit ev_stop;
        bit done;
        logic [WIDTH-1:0] nsig;
        ev_start     = st && !m_prev_start;
        ev_stop      = sp && !m_prev_stop;
        done         = 1'b0;
        m_prev_start = st;
        m_prev_stop  = sp;
        m_valid      = 1'b0;
        case (m_phase)
            0: if (ar) m_phase = 1;
            1: if (ev_start) begin
                   m_samples.delete();
                   m_samples.push_back(d);
                   if (ev_stop) done = 1'b1;
                   else         m_phase = 2;
               end
            default: begin
                   m_samples.push_back(d);
                   if (ev_stop) done = 1'b1;
               end
        endcase
        if (done) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                nsig = fold(ch);
`ifdef SIGAN_UNSTABLE_EN
                m_unstable[ch] = m_have_sig && (nsig != m_sig[ch*WIDTH +: WIDTH]);
`endif
                m_sig[ch*WIDTH +: WIDTH] = nsig;
            end
            m_have_sig = 1'b1;
            m_count    = 32'(m_samples.size());
            m_valid    = 1'b1;
            m_phase    = sg ? 0 : 1;
        end
    endtask

    // Called at a falling edge: drive, let the rising edge sample, then compare at the next falling edge.
    task automatic tick(logic st, logic sp, logic [CHANNELS-1:0] d, logic ar);
        bus.start = st;
        bus.stop  = sp;
        bus.data  = d;
        bus.arm   = ar;
        @(posedge clock);
        model_edge(st, sp, d, ar, bus.single);
        @(negedge clock);
        check_outputs("tick");
    endtask

    task automatic do_reset();
        #2 reset_l = 1'b0;
        model_reset();
        #1 check_outputs("reset_async");
        @(posedge clock);
        @(negedge clock);
        check_outputs("reset_held");
        reset_l = 1'b1;
    endtask

    task automatic run_window(int len, logic [CHANNELS-1:0] d_first, logic [CHANNELS-1:0] d_rest);
        tick(1'b0, 1'b0, '0, 1'b0);
        if (len == 1) begin
            tick(1'b1, 1'b1, d_first, 1'b0);
        end else begin
            tick(1'b1, 1'b0, d_first, 1'b0);
            for (int i = 0; i < len - 2; i++) tick(1'b0, 1'b0, d_rest, 1'b0);
            tick(1'b0, 1'b1, d_rest, 1'b0);
        end
    endtask

    task automatic random_ticks(int n, bit vary_single);
        logic [CHANNELS-1:0] rd;
        for (int i = 0; i < n; i++) begin
            if (vary_single && $urandom_range(0, 15) == 0) bus.single = ~bus.single;
            rd = CHANNELS'($urandom);
            tick(logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 4) == 0),
                 rd, logic'($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        int v0;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.data   = '0;
        bus.single = 1'b0;
        bus.arm    = 1'b0;
        reset_l    = 1'b0;
        model_reset();
        @(negedge clock);
        check_outputs("por");
        reset_l = 1'b1;

        // One-clock windows on channel 0 and on channel 1.
        run_window(1, 2'b01, 2'b00);
        check("one_clock_ch0.signature", 64'(bus.signature), 64'h0000_0001);
        check("one_clock_ch0.count",     64'(bus.count),     64'd1);
        check("one_clock_ch0.sig_valid", 64'(bus.sig_valid), 64'd1);
        tick(1'b0, 1'b0, '0, 1'b0);
        check("one_clock_ch0.pulse_end", 64'(bus.sig_valid), 64'd0);
        run_window(1, 2'b10, 2'b00);
        check("one_clock_ch1.signature", 64'(bus.signature), 64'h0001_0000);

        // Single seed bit propagated through 17- and 16-clock windows.
        run_window(17, 2'b01, 2'b00);
        check("win17.count", 64'(bus.count), 64'd17);
        run_window(16, 2'b01, 2'b00);
        check("win16.count", 64'(bus.count), 64'd16);

        random_ticks(400, 1'b0);

        // One-shot: nothing happens until armed, then exactly one window, then back to idle.
        bus.single = 1'b1;
        do_reset();
        v0 = n_valid_seen;
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b1, 2'b11, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, 2'b01, 1'b0);
        tick(1'b0, 1'b1, 2'b01, 1'b0);
        check("oneshot_unarmed.pulses", 64'(n_valid_seen - v0), 64'd0);
        tick(1'b0, 1'b0, '0, 1'b1);
        run_window(4, 2'b11, 2'b01);
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b1, 2'b10, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        check("oneshot_armed.pulses", 64'(n_valid_seen - v0), 64'd1);

        // Reset mid-window aborts it; the following window completes normally.
        bus.single = 1'b0;
        do_reset();
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, 2'b11, 1'b0);
        tick(1'b0, 1'b0, 2'b10, 1'b0);
        tick(1'b0, 1'b0, 2'b01, 1'b0);
        check("mid_window.gate", 64'(bus.gate), 64'd1);
        v0 = n_valid_seen;
        do_reset();
        tick(1'b0, 1'b1, 2'b11, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        check("aborted.pulses", 64'(n_valid_seen - v0), 64'd0);
        check("aborted.signature", 64'(bus.signature), 64'd0);
        run_window(3, 2'b10, 2'b11);
        check("after_abort.pulses", 64'(n_valid_seen - v0), 64'd1);

        random_ticks(600, 1'b1);

`ifdef SIGAN_UNSTABLE_EN
        bus.single = 1'b0;
        do_reset();
        run_window(5, 2'b11, 2'b11);
        check("unstable.first", 64'(bus.unstable), 64'd0);
        run_window(5, 2'b11, 2'b11);
        check("unstable.repeat", 64'(bus.unstable), 64'd0);
        run_window(5, 2'b10, 2'b11);
        check("unstable.flipped", 64'(bus.unstable), 64'b01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
